// File: rtl/iss_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// iss_port_arbiter_if
// Bundles the request/pop handshakes of the Issue Queue and Load/Store Queue,
// the execute-stage consume strobe, the registered issue slot and the issue
// statistics counters into one interface.
//   master : the environment side (queues + execute stage) drives requests,
//            entry data and EX_ready_IN; it observes grants, slot and counters.
//   slave  : the arbiter side.
// -----------------------------------------------------------------------------
interface iss_port_arbiter_if #(
    parameter int DATA_WIDTH = 137,
    parameter int CNT_WIDTH  = 16
);
    logic                  IQ_req_IN;
    logic [DATA_WIDTH-1:0] IQ_data_IN;
    logic                  LSQ_req_IN;
    logic [DATA_WIDTH-1:0] LSQ_data_IN;
    logic                  EX_ready_IN;
    logic                  IQ_grant_OUT;
    logic                  LSQ_grant_OUT;
    logic                  ISS_valid_OUT;
    logic                  ISS_mem_OUT;
    logic [DATA_WIDTH-1:0] ISS_data_OUT;
    logic [CNT_WIDTH-1:0]  IQ_issued_OUT;
    logic [CNT_WIDTH-1:0]  LSQ_issued_OUT;

    modport master (
        output IQ_req_IN, IQ_data_IN, LSQ_req_IN, LSQ_data_IN, EX_ready_IN,
        input  IQ_grant_OUT, LSQ_grant_OUT, ISS_valid_OUT, ISS_mem_OUT,
               ISS_data_OUT, IQ_issued_OUT, LSQ_issued_OUT
    );

    modport slave (
        input  IQ_req_IN, IQ_data_IN, LSQ_req_IN, LSQ_data_IN, EX_ready_IN,
        output IQ_grant_OUT, LSQ_grant_OUT, ISS_valid_OUT, ISS_mem_OUT,
               ISS_data_OUT, IQ_issued_OUT, LSQ_issued_OUT
    );
endinterface

// File: rtl/iss_port_arbiter.sv
// -----------------------------------------------------------------------------
// iss_port_arbiter
// Picks at most one ready head per cycle from the Issue Queue or the
// Load/Store Queue, pops it with a single-cycle combinational grant and
// captures it into a registered issue slot feeding the execute stage.
// MODE 0 alternates on ties with a one-bit pointer; MODE 1 favours the IQ but
// lets the LSQ through once it has been denied STARVE_LIMIT cycles in a row.
// Ports:
//   CLK     rising-edge clock
//   RESET   synchronous active-high reset
//   FREEZE  global stall: no grants, all state holds, EX_ready_IN ignored
//   bus     slave side of iss_port_arbiter_if (requests, data, EX_ready_IN,
//           grants, issue slot valid/mem/data, per-source issue counters)
// -----------------------------------------------------------------------------
module iss_port_arbiter #(
    parameter int DATA_WIDTH   = 137,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FREEZE,
    iss_port_arbiter_if.slave    bus
);

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    localparam logic [3:0] STARVE_MAX_C = 4'hF;

    logic                  iss_valid_q, iss_valid_d;
    logic                  iss_mem_q,   iss_mem_d;
    logic [DATA_WIDTH-1:0] iss_data_q,  iss_data_d;
    logic [CNT_WIDTH-1:0]  iq_cnt_q,    iq_cnt_d;
    logic [CNT_WIDTH-1:0]  lsq_cnt_q,   lsq_cnt_d;
    logic                  rpr_q,       rpr_d;
    logic [3:0]            starve_q,    starve_d;

    logic accept_s;
    logic lsq_wins_tie_s;
    logic iq_gnt_s;
    logic lsq_gnt_s;

    // Grant decision: the slot can take a new entry when empty or being drained.
    always_comb begin
        accept_s = !RESET && !FREEZE && (!iss_valid_q || bus.EX_ready_IN);
        if (MODE == 0) begin
            lsq_wins_tie_s = rpr_q;
        end else begin
            lsq_wins_tie_s = (starve_q >= STARVE_LIM_C);
        end
        iq_gnt_s  = accept_s && bus.IQ_req_IN  && (!bus.LSQ_req_IN || !lsq_wins_tie_s);
        lsq_gnt_s = accept_s && bus.LSQ_req_IN && (!bus.IQ_req_IN  ||  lsq_wins_tie_s);
    end

    // Next-state for the issue slot, counters, tie pointer and starvation count.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_mem_d   = iss_mem_q;
        iss_data_d  = iss_data_q;
        iq_cnt_d    = iq_cnt_q;
        lsq_cnt_d   = lsq_cnt_q;
        rpr_d       = rpr_q;
        starve_d    = starve_q;

        if (!FREEZE) begin
            // Issue slot: a grant overrides consumption (back-to-back issue).
            if (iq_gnt_s) begin
                iss_valid_d = 1'b1;
                iss_mem_d   = 1'b0;
                iss_data_d  = bus.IQ_data_IN;
            end else if (lsq_gnt_s) begin
                iss_valid_d = 1'b1;
                iss_mem_d   = 1'b1;
                iss_data_d  = bus.LSQ_data_IN;
            end else if (iss_valid_q && bus.EX_ready_IN) begin
                iss_valid_d = 1'b0;
            end else begin
                iss_valid_d = iss_valid_q;
            end

            // Statistics counters wrap silently.
            if (iq_gnt_s) begin
                iq_cnt_d = iq_cnt_q + CNT_WIDTH'(1);
            end else begin
                iq_cnt_d = iq_cnt_q;
            end
            if (lsq_gnt_s) begin
                lsq_cnt_d = lsq_cnt_q + CNT_WIDTH'(1);
            end else begin
                lsq_cnt_d = lsq_cnt_q;
            end

            // Tie pointer points at the source that did not win last.
            if (iq_gnt_s) begin
                rpr_d = 1'b1;
            end else if (lsq_gnt_s) begin
                rpr_d = 1'b0;
            end else begin
                rpr_d = rpr_q;
            end

            // Consecutive LSQ denials; only cycles that could issue count.
            if (!accept_s) begin
                starve_d = starve_q;
            end else if (lsq_gnt_s || !bus.LSQ_req_IN) begin
                starve_d = 4'd0;
            end else if (starve_q != STARVE_MAX_C) begin
                starve_d = starve_q + 4'd1;
            end else begin
                starve_d = starve_q;
            end
        end else begin
            iss_valid_d = iss_valid_q;
        end
    end

    // State registers with synchronous reset; reset drops the slot unconsumed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            iss_valid_q <= 1'b0;
            iss_mem_q   <= 1'b0;
            iss_data_q  <= '0;
            iq_cnt_q    <= '0;
            lsq_cnt_q   <= '0;
            rpr_q       <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_mem_q   <= iss_mem_d;
            iss_data_q  <= iss_data_d;
            iq_cnt_q    <= iq_cnt_d;
            lsq_cnt_q   <= lsq_cnt_d;
            rpr_q       <= rpr_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.IQ_grant_OUT   = iq_gnt_s;
    assign bus.LSQ_grant_OUT  = lsq_gnt_s;
    assign bus.ISS_valid_OUT  = iss_valid_q;
    assign bus.ISS_mem_OUT    = iss_mem_q;
    assign bus.ISS_data_OUT   = iss_data_q;
    assign bus.IQ_issued_OUT  = iq_cnt_q;
    assign bus.LSQ_issued_OUT = lsq_cnt_q;

endmodule

// File: doc/iss_port_arbiter.md
# iss_port_arbiter

Issue-port arbiter between the Issue Queue (IQ) and the Load/Store Queue (LSQ). It picks at most one ready head per cycle and pops it from its queue with a single-cycle grant pulse. The chosen entry goes into a registered issue slot that feeds the execute stage. The block owns the priority state and the starvation escape for the LSQ, and counts issued instructions per source.

## Interface
- DATA_WIDTH, 137: width of an IQ/LSQ entry.
- MODE, 0: 0 = round-robin; 1 = IQ fixed priority with LSQ starvation escape.
- STARVE_LIMIT, 4: MODE 1 only. Number of consecutive denied LSQ cycles after which the LSQ wins (1..15).
- CNT_WIDTH, 16: width of the issue statistics counters.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- FREEZE  in  1  global stall; freezes all state and suppresses grants.
- IQ_req_IN  in  1  IQ has a ready entry selected.
- IQ_data_IN  in  DATA_WIDTH  the selected IQ entry.
- LSQ_req_IN  in  1  LSQ head is ready.
- LSQ_data_IN  in  DATA_WIDTH  LSQ head entry.
- EX_ready_IN  in  1  execute stage consumes the issue slot this cycle.
- IQ_grant_OUT  out  1  combinational pop pulse to the IQ.
- LSQ_grant_OUT  out  1  combinational pop pulse to the LSQ.
- ISS_valid_OUT  out  1  issue slot holds an instruction.
- ISS_mem_OUT  out  1  issue slot instruction came from the LSQ.
- ISS_data_OUT  out  DATA_WIDTH  issue slot contents.
- IQ_issued_OUT  out  CNT_WIDTH  count of IQ grants, wraps modulo 2^CNT_WIDTH.
- LSQ_issued_OUT  out  CNT_WIDTH  count of LSQ grants, wraps modulo 2^CNT_WIDTH.

## Operation
- accept = !RESET && !FREEZE && (!ISS_valid_OUT || EX_ready_IN).
- Grants are asserted only when accept is 1. Grants are one-hot or zero, never both.
- Winner selection when accept is 1:
  - Only one request asserted: that source wins.
  - Both requests asserted, MODE 0: pointer rPr decides; rPr=0 gives IQ, rPr=1 gives LSQ.
  - Both requests asserted, MODE 1: LSQ wins if starve_cnt >= STARVE_LIMIT, otherwise IQ wins.
- rPr (MODE 0): after any grant, rPr <= 1 if IQ won, 0 if LSQ won. It holds when there is no grant.
- starve_cnt (MODE 1, 4-bit):
  - When accept=1, LSQ_req_IN=1 and the LSQ is not granted: increment, saturating at 15.
  - When the LSQ is granted, or accept=1 with LSQ_req_IN=0: clear to 0.
  - When accept=0: hold.
- Issue slot update on each clock edge:
  - Grant this cycle: ISS_data_OUT <= winner data; ISS_valid_OUT <= 1; ISS_mem_OUT <= (winner is LSQ).
  - No grant, but slot consumed (ISS_valid_OUT && EX_ready_IN && !FREEZE): ISS_valid_OUT <= 0; data and mem hold.
  - Otherwise: hold.
- Counters: IQ_issued_OUT and LSQ_issued_OUT increment by 1 on their own grant.
- FREEZE=1: no grants; the slot, rPr, starve_cnt and counters all hold; EX_ready_IN is ignored.

## Timing
- Reset values, all outputs: ISS_valid_OUT=0, ISS_mem_OUT=0, ISS_data_OUT=0, IQ_issued_OUT=0, LSQ_issued_OUT=0. Internal state: rPr=0, starve_cnt=0.
- Grants are 0 during any RESET cycle.
- Reset asserted mid-operation drops the occupied slot without consumption. The queues see no grant that cycle.
- Latency: a request granted in cycle N appears on ISS_valid_OUT/ISS_data_OUT in cycle N+1.
- Throughput: one issue per cycle while EX_ready_IN=1. A back-to-back grant is allowed in the same cycle the slot is consumed.
- Stall with the slot full (EX_ready_IN=0): no grants; requests may stay asserted and are not lost.
- Request data is sampled only in the grant cycle. Queues remove an entry only on a grant pulse.
- Counter wrap: 2^CNT_WIDTH-1 +1 -> 0, with no flag.

## Test plan
- Reset, then IQ_req_IN=1 with data 0xA5 and EX_ready_IN=1 -> IQ_grant_OUT=1 in cycle 1; in cycle 2 ISS_valid_OUT=1, ISS_mem_OUT=0, ISS_data_OUT=0xA5; IQ_issued_OUT=1.
- MODE 0, both requests held for 6 cycles with EX_ready_IN=1 -> grant order IQ, LSQ, IQ, LSQ, IQ, LSQ; both counters end at 3.
- MODE 1, STARVE_LIMIT=4, both requests held -> IQ granted 4 cycles, LSQ granted in cycle 5, IQ in cycle 6; starve_cnt returns to 0 after the LSQ grant.
- Slot full with EX_ready_IN=0 for 3 cycles while both request -> no grants, slot data unchanged; EX_ready_IN=1 -> a grant in that same cycle, new data the next cycle.
- FREEZE=1 for 2 cycles mid-stream with EX_ready_IN=1 -> no grants, all state and counters unchanged; resumes with the same winner that was due.
- RESET asserted while ISS_valid_OUT=1 and both requesting -> no grants that cycle; next cycle all outputs at reset values and rPr=0 (IQ wins the next tie in MODE 0).
